// File: rtl/uxa_kbd_poller_pkg.sv
// Shared constants and types for the UXA keyboard poller: PS/2 set-2 prefix
// codes, adapter register bit positions, FSM encoding and the event record.
package uxa_kbd_poller_pkg;

  // PS/2 set-2 prefix bytes
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_F0 = 8'hF0;

  // Bytes swallowed after an E1 before the single pause event is emitted
  localparam logic [2:0] E1_SKIP_LEN = 3'd7;

  // Adapter status/data register layout
  localparam int REG_AVAIL_BIT = 15;
  localparam int REG_FULL_BIT  = 14;
  localparam int REG_CLK_BIT   = 9;
  localparam int REG_DATA_BIT  = 8;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_READ   = 2'd1,
    ST_DECODE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

endpackage

// File: rtl/uxa_kbd_poller_if.sv
// Bus bundle between the poller, the PS/2 adapter register port and the key
// event consumer. master = poller side, slave = adapter/consumer side.
interface uxa_kbd_poller_if;
  logic        io_stb_o;
  logic        io_we_o;
  logic [1:0]  io_dat_o;
  logic        io_ack_i;
  logic [15:0] io_dat_i;
  logic        ev_valid_o;
  logic        ev_ready_i;
  logic [7:0]  ev_code_o;
  logic        ev_ext_o;
  logic        ev_brk_o;
  logic        ovf_o;
  logic        err_o;
  logic        flag_clr_i;

  modport master (
    output io_stb_o, io_we_o, io_dat_o,
    input  io_ack_i, io_dat_i,
    output ev_valid_o, ev_code_o, ev_ext_o, ev_brk_o,
    input  ev_ready_i,
    output ovf_o, err_o,
    input  flag_clr_i
  );

  modport slave (
    input  io_stb_o, io_we_o, io_dat_o,
    output io_ack_i, io_dat_i,
    input  ev_valid_o, ev_code_o, ev_ext_o, ev_brk_o,
    output ev_ready_i,
    input  ovf_o, err_o,
    output flag_clr_i
  );
endinterface

// File: rtl/uxa_kbd_poll_timer.sv
// Reloadable down-counter with a zero flag. Holds at zero rather than
// wrapping, so a stalled consumer keeps the flag asserted.
module uxa_kbd_poll_timer #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  // Load has priority over decrement; decrement saturates at zero
  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= RST_VAL;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/uxa_kbd_poller.sv
// Polls the UXA PS/2 adapter register, pops received bytes and folds set-2
// prefixes (E0 / F0 / E1 pause) into single key events on a one-entry
// valid/ready output. Sticky flags report adapter FIFO overflow and ack
// timeouts.
module uxa_kbd_poller
  import uxa_kbd_poller_pkg::*;
#(
  parameter int POLL_DIV    = 64,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             sys_clk_i,
  input  logic             sys_reset_i,
  uxa_kbd_poller_if.master bus
);

  localparam logic [15:0] POLL_RELOAD = 16'(POLL_DIV - 1);
  localparam logic [7:0]  ACK_RELOAD  = 8'(ACK_TIMEOUT - 1);

  state_t     state_reg;
  logic       stb_reg;
  logic [15:0] dat_reg;
  logic       ext_reg;
  logic       brk_reg;
  logic [2:0] skip_reg;
  logic       ev_valid_reg;
  key_event_t ev_reg;
  logic       ovf_reg;
  logic       err_reg;
  logic       poll_zero;
  logic       ack_zero;
  logic [7:0] rx_byte;
  logic       line_unused;

  assign rx_byte = dat_reg[7:0];
  // Raw line bits and reserved bits are latched but have no consumer here
  assign line_unused = ^{dat_reg[13:10], dat_reg[REG_CLK_BIT], dat_reg[REG_DATA_BIT]};

  // Poll interval: held at reload outside WAIT so every WAIT entry starts fresh
  uxa_kbd_poll_timer #(.WIDTH(16), .RST_VAL(POLL_RELOAD)) u_poll_timer (
    .clk      (sys_clk_i),
    .srst     (sys_reset_i),
    .load     (state_reg != ST_WAIT),
    .load_val (POLL_RELOAD),
    .dec      (state_reg == ST_WAIT),
    .zero     (poll_zero)
  );

  // Ack timeout: armed while not reading, counts strobe cycles without ack
  uxa_kbd_poll_timer #(.WIDTH(8), .RST_VAL(ACK_RELOAD)) u_ack_timer (
    .clk      (sys_clk_i),
    .srst     (sys_reset_i),
    .load     (state_reg != ST_READ),
    .load_val (ACK_RELOAD),
    .dec      ((state_reg == ST_READ) && !bus.io_ack_i),
    .zero     (ack_zero)
  );

  // Main sequencer: read, decode prefixes, hold event until accepted
  always_ff @(posedge sys_clk_i) begin
    if (sys_reset_i) begin
      state_reg    <= ST_WAIT;
      stb_reg      <= 1'b0;
      dat_reg      <= '0;
      ext_reg      <= 1'b0;
      brk_reg      <= 1'b0;
      skip_reg     <= '0;
      ev_valid_reg <= 1'b0;
      ev_reg       <= '0;
      ovf_reg      <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      // Clear first so a same-cycle set below takes precedence
      if (bus.flag_clr_i) begin
        ovf_reg <= 1'b0;
        err_reg <= 1'b0;
      end

      case (state_reg)
        ST_WAIT: begin
          if (poll_zero && !ev_valid_reg) begin
            state_reg <= ST_READ;
            stb_reg   <= 1'b1;
          end
        end

        ST_READ: begin
          if (bus.io_ack_i) begin
            dat_reg   <= bus.io_dat_i;
            stb_reg   <= 1'b0;
            state_reg <= ST_DECODE;
          end else if (ack_zero) begin
            stb_reg   <= 1'b0;
            err_reg   <= 1'b1;
            state_reg <= ST_WAIT;
          end
        end

        ST_DECODE: begin
          if (dat_reg[REG_FULL_BIT]) begin
            ovf_reg <= 1'b1;
          end
          if (!dat_reg[REG_AVAIL_BIT]) begin
            // Empty read: back off for a full poll interval
            state_reg <= ST_WAIT;
          end else if (skip_reg != 3'd0) begin
            // Inside the pause sequence: swallow, emit once the tail is gone
            skip_reg <= skip_reg - 3'd1;
            if (skip_reg == 3'd1) begin
              ev_reg       <= '{ext: 1'b1, brk: brk_reg, code: SC_E1};
              ev_valid_reg <= 1'b1;
              ext_reg      <= 1'b0;
              brk_reg      <= 1'b0;
              state_reg    <= ST_HOLD;
            end else begin
              stb_reg   <= 1'b1;
              state_reg <= ST_READ;
            end
          end else if (rx_byte == SC_E0) begin
            ext_reg   <= 1'b1;
            stb_reg   <= 1'b1;
            state_reg <= ST_READ;
          end else if (rx_byte == SC_F0) begin
            brk_reg   <= 1'b1;
            stb_reg   <= 1'b1;
            state_reg <= ST_READ;
          end else if (rx_byte == SC_E1) begin
            ext_reg   <= 1'b1;
            skip_reg  <= E1_SKIP_LEN;
            stb_reg   <= 1'b1;
            state_reg <= ST_READ;
          end else begin
            ev_reg       <= '{ext: ext_reg, brk: brk_reg, code: rx_byte};
            ev_valid_reg <= 1'b1;
            ext_reg      <= 1'b0;
            brk_reg      <= 1'b0;
            state_reg    <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (bus.ev_ready_i) begin
            ev_valid_reg <= 1'b0;
            stb_reg      <= 1'b1;
            state_reg    <= ST_READ;
          end
        end

        default: begin
          state_reg <= ST_WAIT;
          stb_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.io_stb_o   = stb_reg;
  assign bus.io_we_o    = 1'b0;
  assign bus.io_dat_o   = 2'b00;
  assign bus.ev_valid_o = ev_valid_reg;
  assign bus.ev_code_o  = ev_reg.code;
  assign bus.ev_ext_o   = ev_reg.ext;
  assign bus.ev_brk_o   = ev_reg.brk;
  assign bus.ovf_o      = ovf_reg;
  assign bus.err_o      = err_reg;

endmodule

// File: tb/tb_uxa_kbd_poller.sv
// Directed bench for uxa_kbd_poller: a small adapter model serves queued
// bytes, a monitor records accepted events, and one linear sequence checks
// each behaviour against hand-computed values.
module tb_uxa_kbd_poller;

  logic sys_clk_i   = 1'b0;
  logic sys_reset_i = 1'b1;

  uxa_kbd_poller_if bus ();

  uxa_kbd_poller #(.POLL_DIV(64), .ACK_TIMEOUT(16)) dut (
    .sys_clk_i   (sys_clk_i),
    .sys_reset_i (sys_reset_i),
    .bus         (bus)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [7:0]  rx_q[$];
  bit          adapter_full = 1'b0;
  bit          ack_en = 1'b1;
  logic [9:0]  evq[$];
  int          lat = -1;
  int          ack_cyc = 0;
  int          hold_stb = 0;
  bit          valid_prev = 1'b0;

  always @(posedge sys_clk_i) cyc <= cyc + 1;

  // Adapter model: acks one cycle after the strobe, pops on a non-empty ack
  initial begin
    bus.io_ack_i = 1'b0;
    bus.io_dat_i = 16'h0000;
    forever begin
      @(posedge sys_clk_i);
      #1;
      if (bus.io_ack_i) begin
        bus.io_ack_i = 1'b0;
        if (bus.io_dat_i[15]) rx_q.delete(0);
      end else if (bus.io_stb_o && ack_en) begin
        bus.io_ack_i = 1'b1;
        bus.io_dat_i = {(rx_q.size() != 0), adapter_full, 6'b000000,
                        (rx_q.size() != 0) ? rx_q[0] : 8'h00};
      end
    end
  end

  // Monitor: accepted events, ack-to-valid latency, strobes during hold
  initial begin
    forever begin
      @(negedge sys_clk_i);
      if (bus.io_stb_o && bus.io_ack_i) ack_cyc = cyc;
      if (bus.ev_valid_o && !valid_prev) lat = cyc - ack_cyc;
      valid_prev = bus.ev_valid_o;
      if (bus.ev_valid_o && bus.ev_ready_i)
        evq.push_back({bus.ev_ext_o, bus.ev_brk_o, bus.ev_code_o});
      if (bus.io_stb_o && bus.ev_valid_o) hold_stb++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_events(input int n, input string tag);
    int k = 0;
    while (evq.size() < n && k < 600) begin
      @(negedge sys_clk_i);
      k++;
    end
    chk(tag, evq.size(), n);
  endtask

  task automatic wait_strobe(input string tag);
    int k = 0;
    while (!bus.io_stb_o && k < 300) begin
      @(negedge sys_clk_i);
      k++;
    end
    chk(tag, {31'd0, bus.io_stb_o}, 32'd1);
  endtask

  task automatic pulse_clr();
    @(posedge sys_clk_i); #1 bus.flag_clr_i = 1'b1;
    @(posedge sys_clk_i); #1 bus.flag_clr_i = 1'b0;
    @(negedge sys_clk_i);
  endtask

  initial begin
    int k;
    bus.ev_ready_i = 1'b1;
    bus.flag_clr_i = 1'b0;

    // Reset: every output low
    repeat (3) @(posedge sys_clk_i);
    @(negedge sys_clk_i);
    chk("reset_outputs",
        {16'd0, bus.io_stb_o, bus.io_we_o, bus.io_dat_o, bus.ev_valid_o, bus.ev_ext_o,
         bus.ev_brk_o, bus.ev_code_o, bus.ovf_o, bus.err_o}, 32'd0);

    // First poll: counter starts at 63, strobe after 64 low cycles
    @(posedge sys_clk_i); #1 sys_reset_i = 1'b0;
    k = 0;
    @(negedge sys_clk_i);
    while (!bus.io_stb_o && k < 200) begin
      k++;
      @(negedge sys_clk_i);
    end
    chk("first_poll_gap", k, 64);

    // Plain make code, latency ack -> valid of two cycles
    rx_q.push_back(8'h1C);
    wait_events(1, "t1_event_count");
    chk("t1_event", {22'd0, evq[0]}, 32'h01C);
    chk("t1_latency", lat, 2);

    // E0 F0 74 -> one extended break event
    rx_q.push_back(8'hE0); rx_q.push_back(8'hF0); rx_q.push_back(8'h74);
    wait_events(2, "t2_event_count");
    repeat (20) @(negedge sys_clk_i);
    chk("t2_no_extra", evq.size(), 2);
    chk("t2_event", {22'd0, evq[1]}, 32'h374);

    // Pause sequence -> one E1 event, then 1C decodes normally
    rx_q.push_back(8'hE1); rx_q.push_back(8'h14); rx_q.push_back(8'h77);
    rx_q.push_back(8'hE1); rx_q.push_back(8'hF0); rx_q.push_back(8'h14);
    rx_q.push_back(8'hF0); rx_q.push_back(8'h77); rx_q.push_back(8'h1C);
    wait_events(4, "t3_event_count");
    repeat (20) @(negedge sys_clk_i);
    chk("t3_no_extra", evq.size(), 4);
    chk("t3_pause_event", {22'd0, evq[2]}, 32'h2E1);
    chk("t3_after_pause", {22'd0, evq[3]}, 32'h01C);

    // Consumer stalls 100 cycles with three bytes queued
    @(posedge sys_clk_i); #1 bus.ev_ready_i = 1'b0;
    rx_q.push_back(8'h1C); rx_q.push_back(8'h32); rx_q.push_back(8'h21);
    repeat (100) @(negedge sys_clk_i);
    chk("t4_hold_valid", {31'd0, bus.ev_valid_o}, 32'd1);
    chk("t4_hold_code", {24'd0, bus.ev_code_o}, 32'h1C);
    chk("t4_none_accepted", evq.size(), 4);
    chk("t4_adapter_left", rx_q.size(), 2);
    chk("t4_no_strobe_in_hold", hold_stb, 0);
    @(posedge sys_clk_i); #1 bus.ev_ready_i = 1'b1;
    wait_events(7, "t4_event_count");
    chk("t4_ev_a", {22'd0, evq[4]}, 32'h01C);
    chk("t4_ev_b", {22'd0, evq[5]}, 32'h032);
    chk("t4_ev_c", {22'd0, evq[6]}, 32'h021);
    chk("t4_no_strobe_in_hold_end", hold_stb, 0);

    // Adapter never acks: strobe held 16 cycles, err set, then cleared
    repeat (10) @(negedge sys_clk_i);
    ack_en = 1'b0;
    wait_strobe("t5_strobe_seen");
    k = 0;
    while (bus.io_stb_o && k < 100) begin
      k++;
      @(negedge sys_clk_i);
    end
    chk("t5_strobe_len", k, 16);
    chk("t5_err_set", {31'd0, bus.err_o}, 32'd1);
    pulse_clr();
    chk("t5_err_cleared", {31'd0, bus.err_o}, 32'd0);
    ack_en = 1'b1;

    // Empty read with FIFO-full: ovf set, no event, DECODE + 64 WAIT cycles
    adapter_full = 1'b1;
    wait_strobe("t6_strobe_seen");
    @(negedge sys_clk_i);
    adapter_full = 1'b0;
    k = 0;
    while (!bus.io_stb_o && k < 200) begin
      k++;
      @(negedge sys_clk_i);
    end
    chk("t6_idle_gap", k, 65);
    chk("t6_ovf_set", {31'd0, bus.ovf_o}, 32'd1);
    chk("t6_no_event", evq.size(), 7);
    repeat (5) @(negedge sys_clk_i);
    pulse_clr();
    chk("t6_ovf_cleared", {31'd0, bus.ovf_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uxa_kbd_poller.md
# uxa_kbd_poller

Bus-mastering consumer sitting directly downstream of the UXA PS/2 adapter. Polls the adapter's 16-bit status/data register over its strobe/ack bus, pops received bytes, folds PS/2 set-2 prefixes (E0 extended, F0 break, E1 pause) into single key events, and presents them on a one-entry valid/ready output. The adapter's 16-byte FIFO absorbs keyboard bursts while the event consumer stalls.

## Interface
- POLL_DIV, 64: idle cycles between polls after an empty read; legal range 1..65535.
- ACK_TIMEOUT, 16: cycles to wait for io_ack_i before aborting a read; legal range 2..255.
- sys_clk_i  in  1  system clock; the only clock.
- sys_reset_i  in  1  synchronous, active-high reset.
- io_stb_o  out  1  read strobe to the adapter.
- io_we_o  out  1  write enable; tied low, reads only.
- io_dat_o  out  2  adapter line-control bits [9:8]; constant 2'b00.
- io_ack_i  in  1  adapter acknowledge.
- io_dat_i  in  16  adapter register: [15] data available, [14] FIFO full, [9:8] raw clock/data, [7:0] byte.
- ev_valid_o  out  1  key event valid.
- ev_ready_i  in  1  consumer accepts the event.
- ev_code_o  out  8  final scan code.
- ev_ext_o  out  1  E0 or E1 prefix seen.
- ev_brk_o  out  1  F0 (release) prefix seen.
- ovf_o  out  1  sticky; adapter FIFO reported full.
- err_o  out  1  sticky; ack timeout.
- flag_clr_i  in  1  clears ovf_o and err_o.

## Operation
- States: WAIT, READ, DECODE, HOLD.
- WAIT: poll counter counts down; at zero, and only when !ev_valid_o, go to READ. Direct entry from DECODE (counter bypassed) after any non-empty read.
- READ: io_stb_o=1. On io_ack_i, latch io_dat_i and go to DECODE. If ACK_TIMEOUT cycles elapse without ack: drop strobe, set err_o, reload counter, go to WAIT.
- An acked read with io_dat_i[15]=1 consumes that byte from the adapter; with [15]=0 it is empty.
- DECODE: empty -> WAIT with counter reloaded to POLL_DIV-1. io_dat_i[14]=1 -> set ovf_o (independently of [15]). With [15]=1 and skip counter nonzero: decrement, discard. Byte E0: set ext. Byte F0: set brk. Byte E1: set ext, load skip counter with 7; on reaching zero emit code E1. Other bytes: load ev_code_o/ev_ext_o/ev_brk_o, assert ev_valid_o, clear ext/brk, go to HOLD. Prefix bytes go back to READ.
- HOLD: ev_valid_o held with stable fields until ev_valid_o && ev_ready_i; then go to READ immediately.
- Prefix flags persist across empty reads; only reset or event emission clears them.
- flag_clr_i coincident with a set event: set wins.

## Timing
- Reset: all outputs 0, state WAIT, counter POLL_DIV-1, ext/brk/skip cleared. Reset mid-read drops io_stb_o next cycle; the adapter may have popped the byte, which is lost.
- io_stb_o rises the cycle after WAIT exits; sampled on ack edge; falls the cycle after ack.
- Final byte acked at cycle N -> ev_valid_o high at N+2.
- Handshake accept at cycle M -> io_stb_o high at M+1.
- One read in flight maximum; strobe never asserted while ev_valid_o is high.

## Structure
- Shared package: scan prefix constants (E0, E1, F0), E1 skip length 7, state encoding, register bit positions 15/14/9/8.
- One sub-module: uxa_kbd_poll_timer (reloadable down-counter with zero flag, reused for poll interval and ack timeout).

## Test plan
- Adapter model returns 1C with [15]=1, ev_ready_i=1 -> one event code 1C, ext=0, brk=0, two cycles after ack.
- Sequence E0 F0 74 -> single event code 74, ext=1, brk=1; no events for prefixes.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event code E1, ext=1; next byte 1C decodes normally.
- ev_ready_i low 100 cycles with 3 bytes queued -> no strobes during hold; events 1C,32,21 delivered in order.
- Adapter never acks -> io_stb_o drops after 16 cycles, err_o=1; flag_clr_i clears it.
- Read returning [15]=0,[14]=1 -> ovf_o=1, no event, next strobe after 64 idle cycles.
